gf_inverse_sbox_seq: RTL and testbench

- Sequential GF(2^8) multiplicative-inverse engine for the subBytes path.
- Directly downstream of the combinational GF multiply/modular-reduce stage: it consumes one reduced product per cycle and iterates it to form x^254 = x^-1.
- Optionally applies the AES affine transform, so the output is the full S-box value.
- Valid/ready handshake on both sides; one byte in flight.

---
 rtl/gf_inverse_sbox_seq_if.sv | 20 ++
 rtl/gf_inverse_sbox_seq.sv | 117 +++++++++++
 tb/tb_gf_inverse_sbox_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/gf_inverse_sbox_seq_if.sv
// rtl/gf_inverse_sbox_seq_if.sv - byte-in / byte-out handshake bundle for the GF(2^8) inverse engine
interface gf_inverse_sbox_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       busy;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_byte, busy
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_byte, busy
  );
endinterface

// File: rtl/gf_inverse_sbox_seq.sv
// rtl/gf_inverse_sbox_seq.sv - sequential GF(2^8) inverse (x^254), optional AES affine under SBOX_AFFINE_EN
module gf_inverse_sbox_seq #(
  parameter logic [8:0] POLY = 9'h11B
`ifdef SBOX_AFFINE_EN
  , parameter logic [7:0] AFFINE_C = 8'h63
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  gf_inverse_sbox_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] x_reg, acc, prod, f_out;
  logic [3:0] step;
  logic       load, last;
  logic       out_valid_q;
  logic [7:0] out_byte_q;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({7'b0, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ ({6'b0, POLY} << (i - 8));
    return p[7:0];
  endfunction

  // Even steps square, odd steps multiply by x: x^2, x^3, x^6, x^7 ... x^127, x^254.
  assign prod = gf_mul(acc, step[0] ? x_reg : acc);

`ifdef SBOX_AFFINE_EN
  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ AFFINE_C[i];
    return r;
  endfunction

  assign f_out = affine(prod);
`else
  assign f_out = prod;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    load         = 1'b0;
    last         = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        bus.busy = 1'b1;
        if (step == 4'd12) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        bus.in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load       = 1'b1;
            state_next = CALC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg       <= 8'h00;
      acc         <= 8'h00;
      step        <= 4'd0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
    end else begin
      if (load) begin
        x_reg <= bus.in_byte;
        acc   <= bus.in_byte;
        step  <= 4'd0;
      end else if (state == CALC) begin
        acc  <= prod;
        step <= step + 4'd1;
      end
      if (last) begin
        out_valid_q <= 1'b1;
        out_byte_q  <= f_out;
      end else if (state == DONE && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;

endmodule

// File: tb/tb_gf_inverse_sbox_seq.sv
// tb/tb_gf_inverse_sbox_seq.sv - directed vector bench for gf_inverse_sbox_seq (either SBOX_AFFINE_EN build)
module tb_gf_inverse_sbox_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf_inverse_sbox_seq_if bus ();

  gf_inverse_sbox_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] inv;
    logic [7:0] sbox;
  } vec_t;

  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pick(input vec_t v);
`ifdef SBOX_AFFINE_EN
    return v.sbox;
`else
    return v.inv;
`endif
  endfunction

  // xtime-style reference multiply, independent of the carry-less/reduce structure
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    for (int y = 1; y < 256; y++)
      if (ref_mul(a, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ref_inv(a);
    return 8'h63 ^ b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4);
  endfunction

  task automatic send_and_get(input logic [7:0] x, output logic [7:0] y, output int lat);
    int n;
    lat = -1;
    y   = 8'h00;
    bus.in_byte   = x;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (bus.out_valid) begin
      lat = n;
      y   = bus.out_byte;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] y, held, exp_b;
    logic       ok;
    int         lat, n, idx, cyc, bcount, nout;
    int         out_cyc[3];
    logic [7:0] out_val[3];
    logic [7:0] seq[3];

    vecs[0] = '{8'h53, 8'hCA, 8'hED};
    vecs[1] = '{8'h00, 8'h00, 8'h63};
    vecs[2] = '{8'h01, 8'h01, 8'h7C};
    vecs[3] = '{8'hFF, 8'h1C, 8'h16};
    vecs[4] = '{8'h02, 8'h8D, 8'h77};
    vecs[5] = '{8'h10, 8'h74, 8'hCA};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_byte", 32'(bus.out_byte), 32'h00);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      send_and_get(vecs[i].x, y, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd13);
      check($sformatf("vec%0d_value_x%02h", i, vecs[i].x), 32'(y), 32'(pick(vecs[i])));
    end

    // Backpressure: result held for 20 cycles, extra in_valid ignored, then same-cycle accept.
    bus.in_byte = 8'hFF; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_byte = 8'h53;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("hold_latency", 32'(n), 32'd13);
    held = bus.out_byte;
    check("hold_value", 32'(held), 32'(pick(vecs[3])));
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.out_byte !== held || bus.in_ready || bus.busy) ok = 1'b0;
    end
    check("hold_stable_20", 32'(ok), 32'd1);
    bus.out_ready = 1'b1;
    #1;
    check("hold_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("hold_release_busy", 32'(bus.busy), 32'd1);
    check("hold_release_out_valid", 32'(bus.out_valid), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("b2b_latency", 32'(n), 32'd13);
    check("b2b_value", 32'(bus.out_byte), 32'(pick(vecs[0])));
    @(posedge clk); #1;

    // Streaming with in_valid and out_ready tied high.
    seq[0] = 8'h53; seq[1] = 8'hFF; seq[2] = 8'h01;
    idx = 0; cyc = 0; bcount = 0; nout = 0;
    bus.in_byte = seq[0]; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      ok = bus.in_valid && bus.in_ready;
      @(posedge clk); #1; cyc++;
      if (ok) begin
        idx++;
        if (idx < 3) bus.in_byte = seq[idx];
        else         bus.in_valid = 1'b0;
      end
      if (bus.busy) bcount++;
      if (bus.out_valid) begin
        if (nout < 3) begin
          out_cyc[nout] = cyc;
          out_val[nout] = bus.out_byte;
        end
        nout++;
      end
    end
    check("stream_count", 32'(nout), 32'd3);
    check("stream_busy_cycles", 32'(bcount), 32'd39);
    if (nout >= 3) begin
      check("stream_first_at", 32'(out_cyc[0]), 32'd14);
      check("stream_gap1", 32'(out_cyc[1] - out_cyc[0]), 32'd14);
      check("stream_gap2", 32'(out_cyc[2] - out_cyc[1]), 32'd14);
      check("stream_val0", 32'(out_val[0]), 32'(pick(vecs[0])));
      check("stream_val1", 32'(out_val[1]), 32'(pick(vecs[3])));
      check("stream_val2", 32'(out_val[2]), 32'(pick(vecs[2])));
    end

    // Asynchronous reset at CALC step 6.
    bus.in_byte = 8'h53; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_out_byte", 32'(bus.out_byte), 32'h00);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    send_and_get(8'h53, y, lat);
    check("post_reset_latency", 32'(lat), 32'd13);
    check("post_reset_value", 32'(y), 32'(pick(vecs[0])));

    // Exhaustive sweep.
    for (int x = 0; x < 256; x++) begin
      send_and_get(8'(x), y, lat);
`ifdef SBOX_AFFINE_EN
      exp_b = ref_sbox(8'(x));
      check($sformatf("sweep_sbox_x%02h", x), 32'(y), 32'(exp_b));
`else
      if (x == 0) check("sweep_inv_x00", 32'(y), 32'h00);
      else        check($sformatf("sweep_inv_x%02h", x), 32'(ref_mul(8'(x), y)), 32'h01);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
